// File: rtl/window_seq_pkg.sv
// ---------------------------------------------------------------------------
// window_seq_pkg
//   Shared definitions for the window-coefficient sequencer:
//   - default parameter values (address width, word width, read latency)
//   - FSM state encodings (IDLE / ARMED / RUN)
//   - frame_len(): number of valid words in one frame for a given address
//     width, with or without the symmetric (mirrored) window option.
// ---------------------------------------------------------------------------
package window_seq_pkg;

    localparam int AWIDTH_DEF   = 10;
    localparam int DWIDTH_DEF   = 64;
    localparam int READ_LAT_DEF = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // A mirrored window walks the stored half-window forwards and then
    // backwards, so the frame is twice the RAM depth.
    function automatic int frame_len(input int aw, input bit mirror);
        if (mirror)
            return 1 << (aw + 1);
        else
            return 1 << aw;
    endfunction

endpackage

// File: rtl/seq_delay_line.sv
// ---------------------------------------------------------------------------
// seq_delay_line
//   Fixed-depth register pipe, shifted every clock, with synchronous clear.
//   Used to carry sample words and their valid / first-word flags alongside
//   the RAM read latency.
//
// Parameters
//   DATA_W  width of the carried word
//   STAGES  number of register stages (>= 1)
//
// Ports
//   clk   in   clock
//   clr   in   synchronous clear of every stage
//   din   in   DATA_W word entering stage 0
//   dout  out  DATA_W word leaving the last stage (STAGES cycles later)
// ---------------------------------------------------------------------------
module seq_delay_line
    import window_seq_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] pipe_p [STAGES];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < STAGES; i++)
                pipe_p[i] <= '0;
        end else begin
            // stage 0 captures the input; later stages shift
            pipe_p[0] <= din;
            for (int i = 1; i < STAGES; i++)
                pipe_p[i] <= pipe_p[i-1];
        end
    end

    assign dout = pipe_p[STAGES-1];

endmodule

// File: rtl/window_coef_sequencer.sv
// ---------------------------------------------------------------------------
// window_coef_sequencer
//   Drives port A of the window-coefficient RAM for the windowing stage in
//   front of the FFT. On a frame sync it issues one coefficient read per
//   valid input word, delays the sample by the RAM read latency and presents
//   sample and coefficient side by side. Between frames a fabric loader may
//   write coefficients through the same port.
//
// Build option
//   MIRROR_EN_EN  symmetric window: the frame is 2^(AWIDTH+1) words and the
//                 second half reads the stored half-window in reverse.
//
// Parameters
//   AWIDTH    RAM address width
//   DWIDTH    sample / coefficient word width
//   READ_LAT  clocks from bram_addr to bram_rd_data (>= 1)
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   sync_in            frame start, qualified by din_valid
//   din_valid/din_data input sample stream
//   arm                1 = keep taking frames, 0 = idle after current frame
//   bram_we/en_a/addr/wr_data/rd_data   RAM port A
//   ld_req/addr/data, ld_ack            coefficient loader handshake
//   dout_valid/data/coef, sync_out      aligned output stream
//   sync_err           sticky flag: sync seen in the middle of a frame
//   busy               1 while a frame is being read
// ---------------------------------------------------------------------------
module window_coef_sequencer
    import window_seq_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_in,
    input  logic              din_valid,
    input  logic [DWIDTH-1:0] din_data,
    input  logic              arm,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [AWIDTH-1:0] bram_addr,
    output logic [DWIDTH-1:0] bram_wr_data,
    input  logic [DWIDTH-1:0] bram_rd_data,
    input  logic              ld_req,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [DWIDTH-1:0] ld_data,
    output logic              ld_ack,
    output logic              dout_valid,
    output logic [DWIDTH-1:0] dout_data,
    output logic [DWIDTH-1:0] dout_coef,
    output logic              sync_out,
    output logic              sync_err,
    output logic              busy
);

`ifdef MIRROR_EN_EN
    localparam bit MIRROR = 1'b1;
    localparam int CWIDTH = AWIDTH + 1;
`else
    localparam bit MIRROR = 1'b0;
    localparam int CWIDTH = AWIDTH;
`endif

    localparam int                FRAME = frame_len(AWIDTH, MIRROR);
    localparam logic [CWIDTH-1:0] LAST  = CWIDTH'(FRAME - 1);

    // Frame position to RAM address. In mirrored mode the upper half of the
    // count walks back down: 2^(A+1)-1-i equals the bitwise inverse of the
    // low AWIDTH bits of i.
    function automatic logic [AWIDTH-1:0] map_addr(input logic [CWIDTH-1:0] c);
`ifdef MIRROR_EN_EN
        if (c[AWIDTH])
            return ~c[AWIDTH-1:0];
        else
            return c[AWIDTH-1:0];
`else
        return c;
`endif
    endfunction

    state_t            state;
    logic [CWIDTH-1:0] count;
    logic              sync_err_r;

    logic              fire;
    logic              grant;
    logic              issue;
    logic              first_word;
    logic [CWIDTH-1:0] count_eff;

    logic [DWIDTH-1:0] data_p;
    logic              vld_p;
    logic              sync_p;

    assign fire = sync_in & din_valid;

    // Decode of the current cycle. count_eff is the frame position used by
    // this cycle's read: a sync word always lands on position 0, both when
    // starting from ARMED and when restarting mid-frame.
    always_comb begin
        grant      = 1'b0;
        issue      = 1'b0;
        first_word = 1'b0;
        count_eff  = count;
        case (state)
            ST_IDLE: begin
                grant = ld_req;
            end
            ST_ARMED: begin
                // frame start wins over a loader write in the same cycle
                if (fire) begin
                    issue      = 1'b1;
                    first_word = 1'b1;
                    count_eff  = '0;
                end else begin
                    grant = ld_req;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    issue = 1'b1;
                    if (sync_in) begin
                        first_word = 1'b1;
                        count_eff  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            sync_err_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm && !grant)
                        state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (fire) begin
                        state <= ST_RUN;
                        count <= CWIDTH'(1);
                    end else if (!arm) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (din_valid) begin
                        if (sync_in && (count != '0))
                            sync_err_r <= 1'b1;
                        if (count_eff == LAST) begin
                            count <= '0;
                            state <= arm ? ST_ARMED : ST_IDLE;
                        end else begin
                            count <= count_eff + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // RAM port A. Outside a grant the address tracks the frame position, so
    // it holds steady across din_valid gaps. Everything is forced low while
    // reset is asserted.
    assign bram_en_a    = rst_n & (grant | issue);
    assign bram_we      = rst_n & grant;
    assign ld_ack       = rst_n & grant;
    assign bram_addr    = !rst_n ? '0 : (grant ? ld_addr : map_addr(count_eff));
    assign bram_wr_data = (rst_n && grant) ? ld_data : '0;

    // p0 -> p(READ_LAT): sample and flags travel with the RAM read
    seq_delay_line #(
        .DATA_W (DWIDTH),
        .STAGES (READ_LAT)
    ) u_data_pipe (
        .clk  (clk),
        .clr  (!rst_n),
        .din  (din_data),
        .dout (data_p)
    );

    seq_delay_line #(
        .DATA_W (1),
        .STAGES (READ_LAT)
    ) u_vld_pipe (
        .clk  (clk),
        .clr  (!rst_n),
        .din  (issue),
        .dout (vld_p)
    );

    seq_delay_line #(
        .DATA_W (1),
        .STAGES (READ_LAT)
    ) u_sync_pipe (
        .clk  (clk),
        .clr  (!rst_n),
        .din  (first_word),
        .dout (sync_p)
    );

    // output stage: RAM data and delayed sample are aligned here
    assign dout_valid = rst_n & vld_p;
    assign sync_out   = rst_n & sync_p;
    assign dout_data  = data_p;
    assign dout_coef  = dout_valid ? bram_rd_data : '0;

    assign sync_err = sync_err_r;
    assign busy     = (state == ST_RUN);

endmodule

// File: tb/tb_window_coef_sequencer.sv
`timescale 1ns/1ps
module tb_window_coef_sequencer;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int RL = 3;
`ifdef MIRROR_EN_EN
    localparam int FRAME = 2048;
`else
    localparam int FRAME = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst_n, sync_in, din_valid, arm;
    logic [DW-1:0] din_data;
    logic          bram_we, bram_en_a;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wr_data, bram_rd_data;
    logic          ld_req, ld_ack;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          dout_valid, sync_out, sync_err, busy;
    logic [DW-1:0] dout_data, dout_coef;

    always #5 clk = ~clk;

    window_coef_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .READ_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .din_valid(din_valid),
        .din_data(din_data), .arm(arm), .bram_we(bram_we), .bram_en_a(bram_en_a),
        .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .dout_valid(dout_valid), .dout_data(dout_data), .dout_coef(dout_coef),
        .sync_out(sync_out), .sync_err(sync_err), .busy(busy)
    );

    // Port-A RAM model with RL-cycle registered read
    logic [DW-1:0] mem  [1<<AW];
    logic [DW-1:0] gold [1<<AW];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (bram_en_a && bram_we)
            mem[bram_addr] = bram_wr_data;
        if (bram_en_a && !bram_we)
            rd_pipe[0] <= mem[bram_addr];
        for (int i = 1; i < RL; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rd_data = rd_pipe[RL-1];

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [DW-1:0] coef;
        logic          sync;
    } exp_t;

    typedef struct packed {
        logic          rst_n, arm, sync, dv, ld_req;
        logic [AW-1:0] ld_addr;
        logic          e_ack, e_we, e_en;
        logic [AW-1:0] e_addr;
        logic          e_busy;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl [14];
    vec_t t;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   outs = 0;
    int   outs0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int k);
`ifdef MIRROR_EN_EN
        if (k < (1 << AW)) return AW'(k);
        return AW'((1 << (AW + 1)) - 1 - k);
`else
        return AW'(k);
`endif
    endfunction

    task automatic drive(input logic r, input logic a, input logic s, input logic v,
                         input logic [DW-1:0] d, input logic lr,
                         input logic [AW-1:0] la, input logic [DW-1:0] ldd);
        rst_n = r; arm = a; sync_in = s; din_valid = v; din_data = d;
        ld_req = lr; ld_addr = la; ld_data = ldd;
        #1;
    endtask

    task automatic expect_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
        exp_t e;
        e.cyc = cyc + RL; e.data = d; e.coef = gold[a]; e.sync = s;
        sbq.push_back(e);
    endtask

    // Compare the aligned output against the scoreboard, then advance a cycle.
    task automatic end_cycle();
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            chk("dout_valid", {63'd0, dout_valid}, 64'd1);
            chk("dout_data", dout_data, sbq[0].data);
            chk("dout_coef", dout_coef, sbq[0].coef);
            chk("sync_out", {63'd0, sync_out}, {63'd0, sbq[0].sync});
            void'(sbq.pop_front());
            outs++;
        end else begin
            chk("dout_valid_bubble", {63'd0, dout_valid}, 64'd0);
            chk("sync_out_bubble", {63'd0, sync_out}, 64'd0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            gold[i] = 64'hC0EF_0000_0000_0000 + 64'(i);
            mem[i]  = gold[i];
        end
        //          rst arm syn dv  lrq addr   ack we  en  eaddr  busy
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,10'd5, 1'b0,1'b0,1'b0,10'd0, 1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,10'd5, 1'b1,1'b1,1'b1,10'd5, 1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,10'd6, 1'b1,1'b1,1'b1,10'd6, 1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b0,1'b0,10'd0, 1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,10'd7, 1'b1,1'b1,1'b1,10'd7, 1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b0,1'b0,10'd0, 1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,10'd0, 1'b0,1'b0,1'b0,10'd0, 1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b0,1'b0,10'd0, 1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,10'd9, 1'b0,1'b0,1'b1,10'd0, 1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,10'd9, 1'b0,1'b0,1'b1,10'd1, 1'b1};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b1,10'd9, 1'b0,1'b0,1'b0,10'd2, 1'b1};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0,10'd0, 1'b0,1'b0,1'b1,10'd2, 1'b1};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b1,1'b1,10'd9, 1'b0,1'b0,1'b0,10'd0, 1'b1};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b0,1'b0,10'd0, 1'b0};

        @(negedge clk);
        drive(0, 0, 0, 0, '0, 0, '0, '0);
        end_cycle();

        // Arbitration / reset table
        for (int r = 0; r < 14; r++) begin
            logic [DW-1:0] d, ldd;
            t   = tbl[r];
            d   = 64'h200 + 64'(r);
            ldd = 64'hAAAA_0000_0000_0000 + 64'(t.ld_addr);
            drive(t.rst_n, t.arm, t.sync, t.dv, d, t.ld_req, t.ld_addr, ldd);
            chk("tbl_ld_ack",    {63'd0, ld_ack},    {63'd0, t.e_ack});
            chk("tbl_bram_we",   {63'd0, bram_we},   {63'd0, t.e_we});
            chk("tbl_bram_en_a", {63'd0, bram_en_a}, {63'd0, t.e_en});
            chk("tbl_bram_addr", {54'd0, bram_addr}, {54'd0, t.e_addr});
            chk("tbl_busy",      {63'd0, busy},      {63'd0, t.e_busy});
            chk("tbl_sync_err",  {63'd0, sync_err},  64'd0);
            if (t.e_we) begin
                chk("tbl_wr_data", bram_wr_data, ldd);
                gold[t.ld_addr] = ldd;
            end
            if (t.e_en && !t.e_we) expect_read(t.e_addr, d, t.sync);
            if (!t.rst_n) sbq.delete();
            end_cycle();
        end

        // Load coef[k]=k in IDLE, then one full frame
        for (int k = 0; k < (1 << AW); k++) begin
            drive(1, 0, 0, 0, '0, 1, AW'(k), 64'(k));
            chk("load_ack", {63'd0, ld_ack}, 64'd1);
            chk("load_we", {63'd0, bram_we}, 64'd1);
            chk("load_addr", {54'd0, bram_addr}, 64'(k));
            gold[k] = 64'(k);
            end_cycle();
        end
        drive(1, 1, 0, 0, '0, 0, '0, '0);
        end_cycle();
        outs0 = outs;
        for (int k = 0; k < FRAME; k++) begin
            drive(1, 1, k == 0, 1, 64'h100 + 64'(k), 0, '0, '0);
            chk("run_addr", {54'd0, bram_addr}, {54'd0, exp_addr(k)});
            chk("run_en", {63'd0, bram_en_a}, 64'd1);
            chk("run_busy", {63'd0, busy}, (k != 0) ? 64'd1 : 64'd0);
            expect_read(exp_addr(k), 64'h100 + 64'(k), k == 0);
            end_cycle();
        end
        drive(1, 1, 0, 0, '0, 0, '0, '0);
        chk("run_busy_after", {63'd0, busy}, 64'd0);
        for (int i = 0; i < RL + 1; i++) end_cycle();
        chk("run_out_count", 64'(outs - outs0), 64'(FRAME));

        // Stall: din_valid low every third cycle
        outs0 = outs;
        begin
            int k = 0;
            int j = 0;
            while (k < FRAME) begin
                logic v;
                v = (j % 3) != 2;
                drive(1, 1, v && (k == 0), v, v ? 64'h100 + 64'(k) : 64'hDEAD, 0, '0, '0);
                chk("stall_addr", {54'd0, bram_addr}, {54'd0, exp_addr(k)});
                chk("stall_en", {63'd0, bram_en_a}, {63'd0, v});
                if (v) begin
                    expect_read(exp_addr(k), 64'h100 + 64'(k), k == 0);
                    k++;
                end
                end_cycle();
                j++;
            end
        end
        drive(1, 1, 0, 0, '0, 0, '0, '0);
        for (int i = 0; i < RL + 1; i++) end_cycle();
        chk("stall_out_count", 64'(outs - outs0), 64'(FRAME));

        // Loader held during RUN from cycle 10; arm dropped mid-frame
        for (int k = 0; k < FRAME; k++) begin
            drive(1, k < 600, k == 0, 1, 64'h100 + 64'(k), k >= 10, 10'd3, 64'h5A5A_0003);
            chk("cont_ack", {63'd0, ld_ack}, 64'd0);
            chk("cont_we", {63'd0, bram_we}, 64'd0);
            chk("cont_addr", {54'd0, bram_addr}, {54'd0, exp_addr(k)});
            expect_read(exp_addr(k), 64'h100 + 64'(k), k == 0);
            end_cycle();
        end
        drive(1, 0, 0, 0, '0, 1, 10'd3, 64'h5A5A_0003);
        chk("cont_ack_after", {63'd0, ld_ack}, 64'd1);
        chk("cont_we_after", {63'd0, bram_we}, 64'd1);
        chk("cont_addr_after", {54'd0, bram_addr}, 64'd3);
        chk("cont_busy_after", {63'd0, busy}, 64'd0);
        gold[3] = 64'h5A5A_0003;
        end_cycle();
        drive(1, 0, 1, 1, 64'h999, 0, '0, '0);
        chk("idle_no_start_en", {63'd0, bram_en_a}, 64'd0);
        end_cycle();
        drive(1, 0, 0, 0, '0, 0, '0, '0);
        chk("idle_no_start_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < RL; i++) end_cycle();

        // Mid-frame sync at count 500, then reset mid-frame
        drive(1, 1, 0, 0, '0, 0, '0, '0);
        end_cycle();
        for (int k = 0; k < 500; k++) begin
            drive(1, 1, k == 0, 1, 64'h100 + 64'(k), 0, '0, '0);
            expect_read(exp_addr(k), 64'h100 + 64'(k), k == 0);
            end_cycle();
        end
        drive(1, 1, 1, 1, 64'h300, 0, '0, '0);
        chk("resync_addr", {54'd0, bram_addr}, 64'd0);
        chk("resync_err_before", {63'd0, sync_err}, 64'd0);
        expect_read(10'd0, 64'h300, 1'b1);
        end_cycle();
        for (int k = 1; k < 6; k++) begin
            drive(1, 1, 0, 1, 64'h300 + 64'(k), 0, '0, '0);
            chk("resync_err", {63'd0, sync_err}, 64'd1);
            chk("resync_next_addr", {54'd0, bram_addr}, {54'd0, exp_addr(k)});
            expect_read(exp_addr(k), 64'h300 + 64'(k), 1'b0);
            end_cycle();
        end
        drive(0, 1, 0, 1, 64'h777, 0, '0, '0);
        sbq.delete();
        end_cycle();
        drive(1, 0, 0, 0, '0, 0, '0, '0);
        chk("reset_sync_err", {63'd0, sync_err}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_addr", {54'd0, bram_addr}, 64'd0);
        for (int i = 0; i < RL + 1; i++) end_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
